mprj_io_retimer: RTL and testbench



---
 rtl/mprj_io_retimer.sv | 112 +++++++++++
 tb/tb_mprj_io_retimer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_retimer.sv
// rtl/mprj_io_retimer.sv - registered management GPIO bank: synchronised, glitch-filtered inputs
// and a freezable retiming pipeline on the out/oeb path.
module mprj_io_retimer #(
    parameter int IO_W       = 38,
    parameter int OEB_W      = 3,
    parameter int IN_SYNC    = 2,
    parameter int FILT_CNT   = 3,
    parameter int OUT_STAGES = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             filt_en,
    input  logic             freeze,
    input  logic [IO_W-1:0]  mgmt_gpio_in,
    output logic [IO_W-1:0]  mgmt_gpio_in_buf,
    output logic [IO_W-1:0]  mgmt_gpio_in_chg,
    input  logic [IO_W-1:0]  mgmt_gpio_out,
    output logic [IO_W-1:0]  mgmt_gpio_out_buf,
    input  logic [OEB_W-1:0] mgmt_gpio_oeb,
    output logic [OEB_W-1:0] mgmt_gpio_oeb_buf
);

    localparam int CW = (FILT_CNT > 0) ? $clog2(FILT_CNT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((FILT_CNT > 0) ? FILT_CNT - 1 : 0);
    localparam bit FILT_PRESENT = (FILT_CNT > 0);
    localparam int PW = IO_W + OEB_W;
    localparam logic [PW-1:0] PIPE_RST = {{IO_W{1'b0}}, {OEB_W{1'b1}}};

    logic [IN_SYNC-1:0][IO_W-1:0] sync_q;
    logic [IO_W-1:0]              s;
    logic [IO_W-1:0]              f_q, f_d;
    logic [IO_W-1:0]              chg_q, chg_d;
    logic [CW-1:0]                c_q [IO_W];
    logic [CW-1:0]                c_d [IO_W];
    logic                         filt_active;
    logic [PW-1:0]                pipe_q [OUT_STAGES];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= mgmt_gpio_in;
            for (int i = 1; i < IN_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s           = sync_q[IN_SYNC-1];
    assign filt_active = filt_en && FILT_PRESENT;

    // A new level is accepted on the FILT_CNT-th consecutive mismatch; any match restarts the count.
    always_comb begin
        f_d   = f_q;
        chg_d = '0;
        c_d   = c_q;
        for (int ch = 0; ch < IO_W; ch++) begin
            if (filt_active) begin
                if (s[ch] == f_q[ch]) begin
                    c_d[ch] = '0;
                end else if (c_q[ch] == CNT_LAST) begin
                    f_d[ch]   = s[ch];
                    c_d[ch]   = '0;
                    chg_d[ch] = 1'b1;
                end else begin
                    c_d[ch] = c_q[ch] + CW'(1);
                end
            end else begin
                f_d[ch]   = s[ch];
                c_d[ch]   = '0;
                chg_d[ch] = (s[ch] != f_q[ch]);
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            f_q   <= '0;
            chg_q <= '0;
            for (int ch = 0; ch < IO_W; ch++) begin
                c_q[ch] <= '0;
            end
        end else begin
            f_q   <= f_d;
            chg_q <= chg_d;
            for (int ch = 0; ch < IO_W; ch++) begin
                c_q[ch] <= c_d[ch];
            end
        end
    end

    assign mgmt_gpio_in_buf = f_q;
    assign mgmt_gpio_in_chg = chg_q;

    // Freeze stalls the whole pipeline so in-flight values survive and resume intact.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < OUT_STAGES; i++) begin
                pipe_q[i] <= PIPE_RST;
            end
        end else if (!freeze) begin
            pipe_q[0] <= {mgmt_gpio_out, mgmt_gpio_oeb};
            for (int i = 1; i < OUT_STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign mgmt_gpio_out_buf = pipe_q[OUT_STAGES-1][PW-1:OEB_W];
    assign mgmt_gpio_oeb_buf = pipe_q[OUT_STAGES-1][OEB_W-1:0];

endmodule

// File: tb/tb_mprj_io_retimer.sv
// tb/tb_mprj_io_retimer.sv - directed scoreboard bench for mprj_io_retimer (OUT_STAGES=2).
module tb_mprj_io_retimer;

    localparam int IO_W  = 38;
    localparam int OEB_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             filt_en;
    logic             freeze;
    logic [IO_W-1:0]  gin;
    logic [IO_W-1:0]  in_buf;
    logic [IO_W-1:0]  in_chg;
    logic [IO_W-1:0]  gout;
    logic [IO_W-1:0]  out_buf;
    logic [OEB_W-1:0] goeb;
    logic [OEB_W-1:0] oeb_buf;

    mprj_io_retimer #(
        .IO_W(IO_W), .OEB_W(OEB_W), .IN_SYNC(2), .FILT_CNT(3), .OUT_STAGES(2)
    ) dut (
        .wb_clk_i          (clk),
        .wb_rst_i          (rst),
        .filt_en           (filt_en),
        .freeze            (freeze),
        .mgmt_gpio_in      (gin),
        .mgmt_gpio_in_buf  (in_buf),
        .mgmt_gpio_in_chg  (in_chg),
        .mgmt_gpio_out     (gout),
        .mgmt_gpio_out_buf (out_buf),
        .mgmt_gpio_oeb     (goeb),
        .mgmt_gpio_oeb_buf (oeb_buf)
    );

    always #5 clk = ~clk;

    localparam int S_INBUF = 0;
    localparam int S_CHG   = 1;
    localparam int S_OUT   = 2;
    localparam int S_OEB   = 3;
    localparam logic [63:0] ALL = '1;

    typedef struct {
        int          due;
        int          sel;
        logic [63:0] mask;
        logic [63:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [63:0] obs(int sel);
        case (sel)
            S_INBUF: return 64'(in_buf);
            S_CHG:   return 64'(in_chg);
            S_OUT:   return 64'(out_buf);
            default: return 64'(oeb_buf);
        endcase
    endfunction

    task automatic expect_at(int due, int sel, logic [63:0] mask, logic [63:0] val, string tag);
        exp_t e;
        e.due  = due;
        e.sel  = sel;
        e.mask = mask;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [63:0] o;
                logic [63:0] x;
                o = obs(sb[i].sel) & sb[i].mask;
                x = sb[i].val & sb[i].mask;
                checks++;
                assert (o === x) else begin
                    errors++;
                    $error("FAIL %s @cyc%0d: got %h expected %h", sb[i].tag, cyc, o, x);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            check_due();
        end
    endtask

    initial begin
        int n;
        logic [63:0] b0, b3, b5, b7;
        b0 = 64'(1) << 0;
        b3 = 64'(1) << 3;
        b5 = 64'(1) << 5;
        b7 = 64'(1) << 7;

        // reset with every input driven high
        rst = 1'b1; filt_en = 1'b1; freeze = 1'b1;
        gin = '1; gout = '1; goeb = '0;
        expect_at(2, S_INBUF, ALL, 64'h0, "rst_in_buf");
        expect_at(2, S_CHG,   ALL, 64'h0, "rst_in_chg");
        expect_at(2, S_OUT,   ALL, 64'h0, "rst_out_buf");
        expect_at(2, S_OEB,   ALL, 64'h7, "rst_oeb_buf");
        step(2);
        rst = 1'b0; freeze = 1'b0; gin = '0; gout = '0; goeb = 3'b111;
        step(4);

        // filtered rise on channel 5
        n = cyc;
        for (int k = 1; k <= 4; k++) begin
            expect_at(n + k, S_INBUF, b5, 64'h0, "rise5_early");
            expect_at(n + k, S_CHG,   ALL, 64'h0, "rise5_chg_early");
        end
        expect_at(n + 5, S_INBUF, b5, b5, "rise5_buf");
        expect_at(n + 5, S_CHG,   ALL, b5, "rise5_chg");
        expect_at(n + 6, S_INBUF, b5, b5, "rise5_hold");
        expect_at(n + 6, S_CHG,   ALL, 64'h0, "rise5_chg_once");
        gin[5] = 1'b1;
        step(7);
        n = cyc;
        expect_at(n + 5, S_CHG,   ALL, b5, "fall5_chg");
        expect_at(n + 6, S_INBUF, ALL, 64'h0, "fall5_buf");
        gin[5] = 1'b0;
        step(7);

        // 2-cycle glitch on channel 7 is rejected
        n = cyc;
        for (int k = 1; k <= 8; k++) begin
            expect_at(n + k, S_INBUF, b7, 64'h0, "glitch7_buf");
            expect_at(n + k, S_CHG,   ALL, 64'h0, "glitch7_chg");
        end
        gin[7] = 1'b1;
        step(2);
        gin[7] = 1'b0;
        step(7);

        // 3-cycle pulse on channel 7 is accepted for exactly 3 cycles
        n = cyc;
        expect_at(n + 4, S_INBUF, b7, 64'h0, "pulse7_pre");
        expect_at(n + 5, S_INBUF, b7, b7, "pulse7_hi1");
        expect_at(n + 6, S_INBUF, b7, b7, "pulse7_hi2");
        expect_at(n + 7, S_INBUF, b7, b7, "pulse7_hi3");
        expect_at(n + 8, S_INBUF, b7, 64'h0, "pulse7_lo");
        expect_at(n + 4, S_CHG, ALL, 64'h0, "pulse7_chg_pre");
        expect_at(n + 5, S_CHG, ALL, b7, "pulse7_chg_rise");
        expect_at(n + 6, S_CHG, ALL, 64'h0, "pulse7_chg_mid");
        expect_at(n + 8, S_CHG, ALL, b7, "pulse7_chg_fall");
        expect_at(n + 9, S_CHG, ALL, 64'h0, "pulse7_chg_post");
        gin[7] = 1'b1;
        step(3);
        gin[7] = 1'b0;
        step(7);

        // bypass: single-cycle pulse on channel 0
        filt_en = 1'b0;
        step(2);
        n = cyc;
        expect_at(n + 2, S_INBUF, b0, 64'h0, "byp0_pre");
        expect_at(n + 3, S_INBUF, b0, b0, "byp0_hi");
        expect_at(n + 4, S_INBUF, b0, 64'h0, "byp0_lo");
        expect_at(n + 2, S_CHG, ALL, 64'h0, "byp0_chg_pre");
        expect_at(n + 3, S_CHG, ALL, b0, "byp0_chg_rise");
        expect_at(n + 4, S_CHG, ALL, b0, "byp0_chg_fall");
        expect_at(n + 5, S_CHG, ALL, 64'h0, "byp0_chg_post");
        gin[0] = 1'b1;
        step(1);
        gin[0] = 1'b0;
        step(5);
        filt_en = 1'b1;
        step(2);

        // output pipeline frozen for 4 edges with data in flight
        n = cyc;
        for (int k = 1; k <= 5; k++) begin
            expect_at(n + k, S_OUT, ALL, 64'h0, "frz_out_hold");
            expect_at(n + k, S_OEB, ALL, 64'h7, "frz_oeb_hold");
        end
        expect_at(n + 6, S_OUT, ALL, 64'h15, "frz_out_release");
        expect_at(n + 6, S_OEB, ALL, 64'h2, "frz_oeb_release");
        gout = 38'h15; goeb = 3'b010;
        step(1);
        freeze = 1'b1;
        step(4);
        freeze = 1'b0;
        step(2);

        // unfrozen two-stage latency
        n = cyc;
        expect_at(n + 1, S_OUT, ALL, 64'h15, "lat_out_s1");
        expect_at(n + 2, S_OUT, ALL, 64'h2a, "lat_out_s2");
        gout = 38'h2a;
        step(3);

        // reset in the middle of a filter count on channel 3
        n = cyc;
        for (int k = 1; k <= 8; k++) begin
            expect_at(n + k, S_INBUF, b3, 64'h0, "rstmid3_early");
        end
        expect_at(n + 4, S_OEB, ALL, 64'h7, "rstmid_oeb");
        expect_at(n + 4, S_OUT, ALL, 64'h0, "rstmid_out");
        expect_at(n + 4, S_CHG, ALL, 64'h0, "rstmid_chg");
        expect_at(n + 5, S_OEB, ALL, 64'h7, "rstmid_oeb_s2");
        expect_at(n + 6, S_OUT, ALL, 64'h2a, "rstmid_out_after");
        expect_at(n + 6, S_OEB, ALL, 64'h2, "rstmid_oeb_after");
        expect_at(n + 9, S_INBUF, b3, b3, "rstmid3_rise");
        expect_at(n + 9, S_CHG, ALL, b3, "rstmid3_chg");
        gin[3] = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
